// File: rtl/bopit_score.sv
// bopit_score: two-player Bop-it score keeper with per-player scores,
// alternating turns and a session high score that survives new games.
module bopit_score #(
    parameter int MAX_SCORE = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [6:0] counter,
    output logic [6:0] counter2,
    output logic [6:0] hs,
    output logic [1:0] turn,
    output logic       game_over,
    output logic       new_high
);
    typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;
    localparam logic [6:0] MAX = 7'(MAX_SCORE);
    state_t state, state_n;
    logic [6:0] counter_n, counter2_n, hs_n, active;
    logic flag, flag_n, playing;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            counter2 <= '0;
            hs       <= '0;
            flag     <= 1'b0;
        end else begin
            state    <= state_n;
            counter  <= counter_n;
            counter2 <= counter2_n;
            hs       <= hs_n;
            flag     <= flag_n;
        end
    // miss has priority over hit; start only matters outside a turn
    always_comb begin
        playing    = state == P1 || state == P2;
        active     = state == P1 ? counter : counter2;
        state_n    = state;
        counter_n  = counter;
        counter2_n = counter2;
        hs_n       = hs;
        flag_n     = flag;
        if (!playing && start) begin
            state_n    = P1;
            counter_n  = '0;
            counter2_n = '0;
            flag_n     = 1'b0;
        end else if (playing && miss) begin
            state_n = state == P1 ? P2 : DONE;
            if (active > hs) begin
                hs_n   = active;
                flag_n = 1'b1;
            end
        end else if (playing && hit) begin
            if (state == P1)
                counter_n = counter >= MAX ? MAX : counter + 7'd1;
            else
                counter2_n = counter2 >= MAX ? MAX : counter2 + 7'd1;
        end
    end
    assign turn      = {state == P2, state == P1};
    assign game_over = state == DONE;
    assign new_high  = flag && game_over;
endmodule

// File: tb/tb_bopit_score.sv
// tb_bopit_score: directed vector table, hand-written corner sequences and
// randomized play checked against a turn-based game model.
module tb_bopit_score;
    localparam int MAXS = 99;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, hit = 1'b0, miss = 1'b0;
    logic [6:0] counter, counter2, hs;
    logic [1:0] turn;
    logic game_over, new_high;
    int vectors = 0, miscompares = 0;
    // game model: phase 0 = idle, 1/2 = that player's turn, 3 = game finished
    int ph, sc1, sc2, mhs;
    bit mnh;

    typedef struct {
        logic s, h, m;
        int c1, c2, h_s, tu, go, nh;
    } vec_t;
    vec_t tbl[$];

    bopit_score #(.MAX_SCORE(MAXS)) dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss),
        .counter(counter), .counter2(counter2), .hs(hs),
        .turn(turn), .game_over(game_over), .new_high(new_high)
    );

    always #5 clk = ~clk;

    function automatic void add(logic s, logic h, logic m, int c1, int c2, int h_s, int tu, int go, int nh);
        vec_t v;
        v = '{s, h, m, c1, c2, h_s, tu, go, nh};
        tbl.push_back(v);
    endfunction

    function automatic void model(logic s, logic h, logic m);
        int a;
        if (ph == 0 || ph == 3) begin
            if (s) begin
                ph = 1; sc1 = 0; sc2 = 0; mnh = 0;
            end
        end else if (m) begin
            a = ph == 1 ? sc1 : sc2;
            if (a > mhs) begin
                mhs = a; mnh = 1;
            end
            ph = ph == 1 ? 2 : 3;
        end else if (h) begin
            if (ph == 1) sc1 = sc1 + 1 > MAXS ? MAXS : sc1 + 1;
            else sc2 = sc2 + 1 > MAXS ? MAXS : sc2 + 1;
        end
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int c1, input int c2, input int h_s,
                           input int tu, input int go, input int nh);
        chk({tag, " counter"}, int'(counter), c1);
        chk({tag, " counter2"}, int'(counter2), c2);
        chk({tag, " hs"}, int'(hs), h_s);
        chk({tag, " turn"}, int'(turn), tu);
        chk({tag, " game_over"}, int'(game_over), go);
        chk({tag, " new_high"}, int'(new_high), nh);
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, sc1, sc2, mhs, ph == 1 ? 1 : ph == 2 ? 2 : 0, ph == 3 ? 1 : 0,
                (mnh && ph == 3) ? 1 : 0);
    endtask

    task automatic cyc(input logic s, input logic h, input logic m);
        start = s; hit = h; miss = m;
        @(posedge clk);
        model(s, h, m);
        @(negedge clk);
        start = 1'b0; hit = 1'b0; miss = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ph = 0; sc1 = 0; sc2 = 0; mhs = 0; mnh = 0;
    endtask

    initial begin
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 0, i, 0, 0, 1, 0, 0);
        add(1, 0, 0, 5, 0, 0, 1, 0, 0);
        add(0, 0, 1, 5, 0, 5, 2, 0, 0);
        for (int i = 1; i <= 3; i++) add(0, 1, 0, 5, i, 5, 2, 0, 0);
        add(1, 0, 0, 5, 3, 5, 2, 0, 0);
        add(0, 0, 1, 5, 3, 5, 0, 1, 1);
        add(0, 1, 0, 5, 3, 5, 0, 1, 1);
        add(0, 0, 1, 5, 3, 5, 0, 1, 1);
        add(1, 1, 0, 0, 0, 5, 1, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 0, i, 0, 5, 1, 0, 0);
        add(0, 0, 1, 5, 0, 5, 2, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 1, 0, 5, i, 5, 2, 0, 0);
        add(0, 0, 1, 5, 7, 7, 0, 1, 1);
        add(1, 0, 1, 0, 0, 7, 1, 0, 0);
        for (int i = 1; i <= 4; i++) add(0, 1, 0, i, 0, 7, 1, 0, 0);
        add(0, 1, 1, 4, 0, 7, 2, 0, 0);
        for (int i = 1; i <= 2; i++) add(0, 1, 0, 4, i, 7, 2, 0, 0);
        add(0, 0, 1, 4, 2, 7, 0, 1, 0);

        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].s, tbl[i].h, tbl[i].m);
            chk_all($sformatf("vec%0d", i), tbl[i].c1, tbl[i].c2, tbl[i].h_s,
                    tbl[i].tu, tbl[i].go, tbl[i].nh);
        end

        do_reset();
        cyc(1, 0, 0);
        for (int i = 1; i <= 120; i++) begin
            cyc(0, 1, 0);
            chk($sformatf("sat hit%0d counter", i), int'(counter), i < MAXS ? i : MAXS);
        end
        cyc(0, 0, 1);
        chk("sat miss hs", int'(hs), MAXS);
        chk("sat miss turn", int'(turn), 2);

        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        chk("pre-rst counter2", int'(counter2), 3);
        #2 rst = 1'b1;
        #1 chk_all("async rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        ph = 0; sc1 = 0; sc2 = 0; mhs = 0; mnh = 0;
        cyc(1, 0, 0);
        chk_model("post-rst start");

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
            chk_model($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bopit_score.md
# bopit_score

Score keeper for the two-player Bop-it game. Counts correct actions for player 1 and player 2 in alternating turns, ends each turn on a miss, and keeps a session high score. It sits directly upstream of the score-to-digit splitter: its `counter`, `counter2` and `hs` outputs feed that stage, which drives the seven-segment display.

## Interface
Parameters:
- `MAX_SCORE`, default 99: saturation value for every score; must be ≤ 99 so scores fit two decimal digits.

Ports:
- `clk`  in  1  system clock (Basys3 100 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a new game.
- `hit`  in  1  single-cycle pulse; the active player performed the correct action.
- `miss`  in  1  single-cycle pulse; wrong action or the action timer expired.
- `counter`  out  7  player 1 score, 0..MAX_SCORE.
- `counter2`  out  7  player 2 score, 0..MAX_SCORE.
- `hs`  out  7  session high score, 0..MAX_SCORE.
- `turn`  out  2  one-hot active player: 01 = P1, 10 = P2, 00 = none.
- `game_over`  out  1  high while in state DONE.
- `new_high`  out  1  high in DONE if this game raised `hs`.

## Operation
- FSM states: IDLE, P1, P2, DONE.
  - IDLE --start--> P1.
  - P1 --miss--> P2.
  - P2 --miss--> DONE.
  - DONE --start--> P1.
- Entering P1 from IDLE or DONE:
  - clears `counter`, `counter2` and the `new_high` flag.
  - does not clear `hs`.
- `hit` behaviour:
  - In P1: `counter` increments by 1, saturating at MAX_SCORE.
  - In P2: `counter2` increments by 1, saturating at MAX_SCORE.
  - In IDLE or DONE: ignored.
- `miss` ends the active turn. On the same edge, if the active score > `hs`, then `hs` takes the active score and the `new_high` flag is set. Ties do not update `hs` or set the flag.
- `hit` and `miss` in the same cycle: `miss` wins. The score is not incremented and the turn ends with the pre-hit score.
- `start` outside IDLE/DONE is ignored. `start` together with `hit` or `miss` in IDLE/DONE: `start` is taken and the other inputs are ignored for that cycle.
- `miss` in IDLE or DONE is ignored.
- `turn`: 01 in P1, 10 in P2, 00 otherwise. `game_over` = (state == DONE). `new_high` = flag AND (state == DONE).
- Arithmetic: all scores are 7-bit unsigned. The comparison with `hs` is unsigned, 7-bit. No value ever exceeds MAX_SCORE.

## Timing
- All state and outputs are registered on the rising edge of `clk`. There are no combinational paths from input to output.
- Reset values (asynchronous, immediate on `rst` = 1):
  - state IDLE, `counter` = 0, `counter2` = 0, `hs` = 0.
  - `turn` = 00, `game_over` = 0, `new_high` = 0.
- Reset mid-game also clears `hs`; the high score persists only across `start`, not across reset.
- Latencies:
  - `hit` sampled at edge t: the new score is visible after edge t.
  - `miss` at edge t: the new `turn`, `hs` and `game_over` are all visible after the same edge t.
- Back-to-back `hit` pulses on consecutive cycles each count. Maximum rate is one increment per clock.
- Inputs are already synchronous, debounced, single-cycle pulses from the upstream timer/button logic. This block adds no debouncing.

## Test plan
- Reset then `start`, 5 `hit` in P1, `miss`, 3 `hit` in P2, `miss` -> `counter` = 5, `counter2` = 3, `hs` = 5, `game_over` = 1, `new_high` = 1, `turn` = 00.
- Second game after that (`hs` = 5): `start` -> both scores 0 and `hs` still 5. P1 scores 5 (tie), P2 scores 7 -> `hs` = 7, `new_high` = 1. A third game with scores 2 and 4 -> `hs` = 7, `new_high` = 0.
- Saturation: 120 `hit` pulses in P1 -> `counter` holds 99 from the 99th pulse on. `miss` -> `hs` = 99.
- Simultaneous `hit` + `miss` in P1 with `counter` = 4 -> `counter` stays 4, `turn` = 10 next cycle. `hit` + `start` in DONE -> new game with `counter` = 0.
- Ignored inputs: `hit`/`miss` in IDLE leave everything at 0. `start` pulsed in P2 leaves state and scores unchanged.
- Asynchronous `rst` asserted mid-P2 between clock edges -> all outputs read 0 immediately, before the next edge. After release, `start` begins from IDLE normally.
